// File: rtl/fft_modulus_frame_reader_if.sv
// Stream port of the FFT modulus frame reader: valid/ready beats with an
// end-of-frame marker. The reader drives the master side; the consumer
// (display/measurement FIFO) sits on the slave side.
interface fft_modulus_frame_reader_if #(
  parameter int DW = 16
) ();
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fft_modulus_frame_reader.sv
// FFT modulus frame reader: streams one frame of samples out of a 1-cycle
// latency synchronous RAM as valid/ready beats, tagging the last beat.
// Storage is the registered output stage plus a 2-entry buffer, so the
// three-deep read loop (strobe, RAM data, output) runs at 1 beat/cycle and
// backpressure never drops a returning read.
// Optional build macro FFT_READER_HALF_SPECTRUM_EN: read only the first half
// of the clipped frame length (real-input half spectrum from address 0).
module fft_modulus_frame_reader #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_start,
  input  logic [AW:0]                i_frame_len,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_ram_rd_en,
  output logic [AW-1:0]              o_ram_rd_addr,
  input  logic [DW-1:0]              i_ram_rd_data,
  fft_modulus_frame_reader_if.master m_if
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  state_t              r_state, w_state_nxt;
  logic [AW:0]         r_len, r_issued;
  logic [AW-1:0]       r_addr;
  // [0] = read strobe on the RAM port, [1] = its data on i_ram_rd_data
  logic [1:0]          r_vld_pipe, r_last_pipe;
  logic                r_out_vld, r_out_last, r_done;
  logic [DW-1:0]       r_out_data;
  logic [1:0][DW-1:0]  r_fifo_data;
  logic [1:0]          r_fifo_last;
  logic [1:0]          r_fifo_cnt;

  logic [AW:0]         w_len_clip, w_len_eff;
  logic                w_start_acc, w_pop, w_last_hs, w_cap, w_take;
  logic                w_issue, w_done_nxt, w_room;
  logic [2:0]          w_outstanding;

  assign w_len_clip = (i_frame_len > MAX_LEN) ? MAX_LEN : i_frame_len;
`ifdef FFT_READER_HALF_SPECTRUM_EN
  assign w_len_eff  = w_len_clip >> 1;
`else
  assign w_len_eff  = w_len_clip;
`endif

  assign w_start_acc = (r_state == IDLE) & i_start & ~i_abort;
  assign w_pop       = r_out_vld & m_if.m_ready;
  assign w_last_hs   = w_pop & r_out_last;
  assign w_cap       = r_vld_pipe[1];
  assign w_take      = ~r_out_vld | w_pop;

  // Every issued read lands somewhere: count output stage, buffer and both
  // read pipeline slots, and only issue while all of them still fit.
  assign w_outstanding = {2'b0, r_out_vld} + {1'b0, r_fifo_cnt}
                       + {2'b0, r_vld_pipe[0]} + {2'b0, r_vld_pipe[1]};
  assign w_room        = (w_outstanding - {2'b0, w_pop}) < 3'd3;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: abort beats everything, an empty frame finishes at once
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_start_acc) w_state_nxt = RUN;
      RUN:  if (i_abort || r_len == '0 || w_last_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-state decisions: read issue and the done pulse request
  always_comb begin
    w_issue    = 1'b0;
    w_done_nxt = 1'b0;
    if (r_state == RUN && !i_abort) begin
      w_issue    = (r_issued < r_len) & w_room;
      w_done_nxt = (r_len == '0) | w_last_hs;
    end
  end

  // Frame counters, read strobe pipeline and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_issued    <= '0;
      r_addr      <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_start_acc) begin
        r_len    <= w_len_eff;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + (AW+1)'(1);
      end
      if (w_issue) r_addr <= r_issued[AW-1:0];
      // abort drops reads still in flight so they are ignored on return
      if (i_abort) begin
        r_vld_pipe  <= '0;
        r_last_pipe <= '0;
      end else begin
        r_vld_pipe  <= {r_vld_pipe[0], w_issue};
        r_last_pipe <= {r_last_pipe[0],
                        w_issue & ((r_issued + (AW+1)'(1)) == r_len)};
      end
    end
  end

  // Output stage refills from the buffer head first, else straight from RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_fifo_data <= '0;
      r_fifo_last <= '0;
      r_fifo_cnt  <= '0;
    end else if (i_abort) begin
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_fifo_cnt <= '0;
    end else if (w_take) begin
      if (r_fifo_cnt != 2'd0) begin
        r_out_vld      <= 1'b1;
        r_out_data     <= r_fifo_data[0];
        r_out_last     <= r_fifo_last[0];
        r_fifo_data[0] <= r_fifo_data[1];
        r_fifo_last[0] <= r_fifo_last[1];
        if (w_cap) begin
          // one in, one out: the new sample goes behind what remains
          r_fifo_data[r_fifo_cnt - 2'd1] <= i_ram_rd_data;
          r_fifo_last[r_fifo_cnt - 2'd1] <= r_last_pipe[1];
        end else begin
          r_fifo_cnt <= r_fifo_cnt - 2'd1;
        end
      end else begin
        r_out_vld <= w_cap;
        if (w_cap) begin
          r_out_data <= i_ram_rd_data;
          r_out_last <= r_last_pipe[1];
        end
      end
    end else if (w_cap) begin
      r_fifo_data[r_fifo_cnt[0]] <= i_ram_rd_data;
      r_fifo_last[r_fifo_cnt[0]] <= r_last_pipe[1];
      r_fifo_cnt                 <= r_fifo_cnt + 2'd1;
    end
  end

  assign o_busy        = (r_state == RUN);
  assign o_done        = r_done;
  assign o_ram_rd_en   = r_vld_pipe[0];
  assign o_ram_rd_addr = r_addr;
  assign m_if.m_valid  = r_out_vld;
  assign m_if.m_data   = r_out_data;
  assign m_if.m_last   = r_out_last;

endmodule

// File: tb/tb_fft_modulus_frame_reader.sv
// Directed bench for fft_modulus_frame_reader: RAM model holds 0x100+i,
// frames are started and the stream, read strobes and done pulse are
// checked against hand-derived cycle numbers (cycle 0 = after start edge).
module tb_fft_modulus_frame_reader;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start, i_abort;
  logic [AW:0]   i_frame_len;
  logic          o_busy, o_done, o_ram_rd_en;
  logic [AW-1:0] o_ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] mem [1024];

  int n_chk = 0;
  int n_err = 0;

  fft_modulus_frame_reader_if #(.DW(DW)) s_if ();

  fft_modulus_frame_reader #(.DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_frame_len   (i_frame_len),
    .i_abort       (i_abort),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_ram_rd_en   (o_ram_rd_en),
    .o_ram_rd_addr (o_ram_rd_addr),
    .i_ram_rd_data (ram_rd_data),
    .m_if          (s_if)
  );

  always #5 clk = ~clk;

  // synchronous RAM, one cycle read latency
  always @(posedge clk) if (o_ram_rd_en) ram_rd_data <= mem[o_ram_rd_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int exp_len(input int f);
    int l;
    l = (f > 1024) ? 1024 : f;
`ifdef FFT_READER_HALF_SPECTRUM_EN
    l = l >> 1;
`endif
    return l;
  endfunction

  // Run one frame; rnd randomises m_ready, xs re-pulses start while busy.
  task automatic run_frame(input int flen, input bit rnd, input int xs);
    int en, n, first_c, done_c, rd_cnt, max_addr;
    bit stall, hs;
    logic [DW-1:0] pd;
    en = exp_len(flen);
    n = 0; first_c = -1; done_c = -1; rd_cnt = 0; max_addr = -1;
    stall = 1'b0; pd = '0;
    @(negedge clk);
    i_frame_len = (AW+1)'(flen);
    i_start = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      i_start = (c == xs);
      if (c == xs) i_frame_len = (AW+1)'(3);
      if (c == 0) chk("busy_c0", 32'(o_busy), 32'd1);
      if (o_ram_rd_en) begin
        rd_cnt++;
        if (int'(o_ram_rd_addr) > max_addr) max_addr = int'(o_ram_rd_addr);
      end
      if (stall) begin
        chk("stall_vld", 32'(s_if.m_valid), 32'd1);
        chk("stall_data", 32'(s_if.m_data), 32'(pd));
      end
      s_if.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = s_if.m_valid & s_if.m_ready;
      if (hs) begin
        chk("beat_data", 32'(s_if.m_data), 32'(16'h100 + n));
        chk("beat_last", 32'(s_if.m_last), 32'(n == en - 1));
        if (n == 0) first_c = c;
        n++;
      end
      stall = s_if.m_valid & ~s_if.m_ready;
      pd = s_if.m_data;
      if (o_done) begin
        done_c = c;
        chk("busy_at_done", 32'(o_busy), 32'd0);
        break;
      end
    end
    i_start = 1'b0;
    chk("beats", n, en);
    chk("rd_cnt", rd_cnt, en);
    if (en > 0) chk("max_addr", max_addr, en - 1);
    if (!rnd) chk("done_cyc", done_c, (en == 0) ? 1 : en + 3);
    else      chk("done_seen", 32'(done_c >= 0), 32'd1);
    if (!rnd && en > 0) chk("first_cyc", first_c, 3);
    @(negedge clk);
    chk("done_one_pulse", 32'(o_done), 32'd0);
  endtask

  initial begin
    int n;
    bit quiet_bad, done_any;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(16'h100 + i);
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_frame_len = '0;
    s_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_flags", 32'({o_busy, o_done, o_ram_rd_en, s_if.m_valid, s_if.m_last}), 32'd0);
    chk("rst_addr", 32'(o_ram_rd_addr), 32'd0);
    chk("rst_data", 32'(s_if.m_data), 32'd0);
    rst_n = 1'b1;

    run_frame(8, 1'b0, 5);      // extra start at cycle 5 must be ignored
    run_frame(16, 1'b1, -1);
    run_frame(0, 1'b0, -1);
    run_frame(1, 1'b0, -1);
    run_frame(1024, 1'b0, -1);
    run_frame(2047, 1'b0, -1);

    // abort after the third beat while stalled
    @(negedge clk);
    i_frame_len = (AW+1)'(8);
    i_start = 1'b1;
    n = 0; quiet_bad = 1'b0; done_any = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_abort = (c == 6);
      if (c == 6) chk("pre_abort_vld", 32'(s_if.m_valid), 32'd1);
      if (c == 7) begin
        chk("abort_vld", 32'(s_if.m_valid), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
      end
      if (c > 7 && (s_if.m_valid || o_ram_rd_en || o_busy)) quiet_bad = 1'b1;
      if (o_done) done_any = 1'b1;
      s_if.m_ready = (c >= 3 && c <= 5);
      if (s_if.m_valid && s_if.m_ready) n++;
    end
    chk("abort_beats", n, 3);
    chk("abort_no_done", 32'(done_any), 32'd0);
    chk("abort_quiet", 32'(quiet_bad), 32'd0);
    run_frame(4, 1'b0, -1);

    // reset in the middle of a frame
    @(negedge clk);
    i_frame_len = (AW+1)'(8);
    i_start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      s_if.m_ready = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 32'({o_busy, o_done, o_ram_rd_en, s_if.m_valid, s_if.m_last}), 32'd0);
    chk("midrst_addr", 32'(o_ram_rd_addr), 32'd0);
    chk("midrst_data", 32'(s_if.m_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s_if.m_ready = 1'b1;
    quiet_bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_done || s_if.m_valid || o_busy) quiet_bad = 1'b1;
    end
    chk("post_rst_quiet", 32'(quiet_bad), 32'd0);
    run_frame(8, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
